// File: rtl/scan_select_sequencer_if.sv
// scan_select_sequencer_if: run controls in, decoder select and blanking out.
interface scan_select_sequencer_if;
    logic       en;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       blank;
    logic       frame;
    modport master (output en, mask, input sel, blank, frame);
    modport slave  (input en, mask, output sel, blank, frame);
endinterface

// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: steps a decoder select through enabled mask positions with dwell and blanking.
module scan_select_sequencer #(
    parameter int DWELL     = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scan_select_sequencer_if.slave  bus
);
    localparam int MX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW = $clog2((MX > 2) ? MX : 2);
    localparam logic [CW-1:0] DW_END = CW'(DWELL - 1);
    localparam logic [CW-1:0] GP_END = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d, nxt_q, nxt_d, nxt, lo, idx;
    logic          blank_q, blank_d, frame_q, frame_d, wrap_q, wrap_d, wrap, found;

    // circular search strictly after sel; k=4 lands back on sel itself
    always_comb begin
        nxt   = sel_q;
        wrap  = 1'b1;
        found = 1'b0;
        idx   = sel_q;
        for (int k = 1; k <= 4; k++) begin
            idx = sel_q + 2'(k);
            if (!found && bus.mask[idx]) begin
                nxt   = idx;
                wrap  = idx <= sel_q;
                found = 1'b1;
            end
        end
        lo = bus.mask[0] ? 2'd0 : bus.mask[1] ? 2'd1 : bus.mask[2] ? 2'd2 : 2'd3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        blank_d = blank_q;
        frame_d = 1'b0;
        nxt_d   = nxt_q;
        wrap_d  = wrap_q;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            blank_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.mask != 4'd0) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    sel_d   = lo;
                    blank_d = 1'b0;
                    frame_d = 1'b1;
                end
                SHOW: if (cnt_q != DW_END) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (bus.mask == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    blank_d = 1'b1;
                end else if (BLANK_CYC == 0) begin
                    cnt_d   = '0;
                    sel_d   = nxt;
                    frame_d = wrap;
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                    blank_d = 1'b1;
                    nxt_d   = nxt;
                    wrap_d  = wrap;
                end
                GAP: if (cnt_q != GP_END) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    sel_d   = nxt_q;
                    blank_d = 1'b0;
                    frame_d = wrap_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
            nxt_q   <= 2'd0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
            nxt_q   <= nxt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.blank = blank_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_scan_select_sequencer.sv
// tb_scan_select_sequencer: directed vectors for the default scanner plus a DWELL=1/BLANK_CYC=0 instance.
module tb_scan_select_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    scan_select_sequencer_if a_if();
    scan_select_sequencer_if b_if();

    scan_select_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(a_if));
    scan_select_sequencer #(.DWELL(1), .BLANK_CYC(0)) dut_z (.clk(clk), .rst_n(rst_n), .bus(b_if));

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [1:0] sel;
        logic       blank;
        logic       frame;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t v(input logic e, input logic [3:0] m, input logic [1:0] s,
                               input logic b, input logic f);
        vec_t r;
        r.en = e; r.mask = m; r.sel = s; r.blank = b; r.frame = f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [1:0] s, input logic b, input logic f,
                       input logic [1:0] es, input logic eb, input logic ef);
        checks++;
        if (s !== es || b !== eb || f !== ef) begin
            errors++;
            $display("FAIL %s: got sel=%0d blank=%0b frame=%0b, want sel=%0d blank=%0b frame=%0b",
                     name, s, b, f, es, eb, ef);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.en = 1'b0; a_if.mask = 4'd0;
        b_if.en = 1'b0; b_if.mask = 4'd0;
        // sparse scan, mask drop mid-dwell, single position, en drop, restart
        tbl[0]  = v(1, 4'b1010, 1, 0, 1);
        tbl[1]  = v(1, 4'b1010, 1, 0, 0);
        tbl[2]  = v(1, 4'b1010, 1, 0, 0);
        tbl[3]  = v(1, 4'b1010, 1, 0, 0);
        tbl[4]  = v(1, 4'b1010, 1, 1, 0);
        tbl[5]  = v(1, 4'b1010, 3, 0, 0);
        tbl[6]  = v(1, 4'b1010, 3, 0, 0);
        tbl[7]  = v(1, 4'b1010, 3, 0, 0);
        tbl[8]  = v(1, 4'b1010, 3, 0, 0);
        tbl[9]  = v(1, 4'b1010, 3, 1, 0);
        tbl[10] = v(1, 4'b1010, 1, 0, 1);
        tbl[11] = v(1, 4'b0000, 1, 0, 0);
        tbl[12] = v(1, 4'b0000, 1, 0, 0);
        tbl[13] = v(1, 4'b0000, 1, 0, 0);
        tbl[14] = v(1, 4'b0000, 1, 1, 0);
        tbl[15] = v(1, 4'b0000, 1, 1, 0);
        tbl[16] = v(1, 4'b0100, 2, 0, 1);
        tbl[17] = v(1, 4'b0100, 2, 0, 0);
        tbl[18] = v(1, 4'b0100, 2, 0, 0);
        tbl[19] = v(1, 4'b0100, 2, 0, 0);
        tbl[20] = v(1, 4'b0100, 2, 1, 0);
        tbl[21] = v(1, 4'b0100, 2, 0, 1);
        tbl[22] = v(1, 4'b0100, 2, 0, 0);
        tbl[23] = v(0, 4'b0100, 2, 1, 0);
        tbl[24] = v(0, 4'b1111, 2, 1, 0);
        tbl[25] = v(1, 4'b1111, 0, 0, 1);

        repeat (2) cyc();
        chk("reset", a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("idle%0d", i), a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 26; i++) begin
            a_if.en = tbl[i].en;
            a_if.mask = tbl[i].mask;
            cyc();
            chk($sformatf("vec%0d", i), a_if.sel, a_if.blank, a_if.frame,
                tbl[i].sel, tbl[i].blank, tbl[i].frame);
        end

        // full scan: t counts cycles since the frame pulse of vec25
        for (int t = 1; t <= 47; t++) begin
            cyc();
            chk($sformatf("scan_t%0d", t), a_if.sel, a_if.blank, a_if.frame,
                2'((t % 20) / 5), (t % 5) == 4, (t % 20) == 0);
        end

        #3 rst_n = 1'b0;
        #1 chk("async_rst", a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b1, 1'b0);
        cyc();
        chk("rst_held", a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("restart", a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b0, 1'b1);
        cyc();
        chk("restart_next", a_if.sel, a_if.blank, a_if.frame, 2'd0, 1'b0, 1'b0);

        // zero-gap, one-cycle dwell: single bit keeps frame high
        b_if.en = 1'b1;
        b_if.mask = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("z_single%0d", i), b_if.sel, b_if.blank, b_if.frame, 2'd2, 1'b0, 1'b1);
        end
        b_if.mask = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("z_pair%0d", i), b_if.sel, b_if.blank, b_if.frame,
                2'(i % 2), 1'b0, (i % 2) == 0);
        end
        b_if.en = 1'b0;
        cyc();
        chk("z_stop", b_if.sel, b_if.blank, b_if.frame, 2'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scan_select_sequencer.md
# scan_select_sequencer

Timed select generator that sits directly upstream of the team's active-low 2-to-4 decoder. It steps a 2-bit select through the enabled positions of a 4-bit mask, holds each position for a programmable dwell time, and inserts programmable blanking gaps between positions. Its `sel` output drives the decoder's `a` input, and `blank` tells the consuming logic to force all decoder outputs inactive (high). A typical use is multiplexed four-digit display scanning.

## Interface
- `DWELL`, default 4: cycles each position is shown; legal range ≥ 1.
- `BLANK_CYC`, default 1: blanking cycles between positions; legal range ≥ 0.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable, active-high.
- `mask`  in  4  position enable; bit i allows select value i.
- `sel`  out  2  current position; connects to the decoder's `a`.
- `blank`  out  1  high means all decoder outputs must be held inactive.
- `frame`  out  1  one-cycle pulse on the first SHOW cycle of each scan frame.

## Operation
- States: IDLE, SHOW, GAP. A dwell/gap counter is sized `$clog2(max(DWELL,BLANK_CYC,2))`.
- Reset (async): state=IDLE, `sel`=0, `blank`=1, `frame`=0, counter=0.
- IDLE:
  - `blank`=1 and `sel` holds its last value.
  - If `en`=1 and `mask`≠0, go to SHOW with `sel` = lowest set bit of `mask`, and assert `frame`.
- SHOW:
  - `blank`=0 and `sel` is held.
  - The counter runs from 0 to DWELL-1.
  - At DWELL-1 (the decision point), choose the next position. If `BLANK_CYC`=0, go straight to SHOW at that position; otherwise go to GAP.
- GAP:
  - `blank`=1 and `sel` keeps the old position.
  - The counter runs from 0 to BLANK_CYC-1, then the block goes to SHOW at the next position.
- Next-position rule:
  - The next position is the first set bit of `mask` strictly after the current `sel`, searching circularly 0→1→2→3→0.
  - `mask` is sampled only at decision points.
  - If the chosen index is ≤ the current one (wrap, or only one bit set), assert `frame` in the first cycle of the following SHOW.
- `mask`=0 at a decision point: go to IDLE at the next edge, with `blank`=1.
- `en`=0 in any state: go to IDLE at the next edge and clear the counter.
  - No pending `frame` is issued.
  - A restart always begins at the lowest set bit and asserts `frame`.
- `mask` changes mid-dwell or mid-gap have no effect until the next decision point.
- `frame` is only ever high while `blank`=0. It is never high for two consecutive cycles unless `BLANK_CYC`=0, DWELL=1 and only one mask bit is set; in that case it stays high continuously.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start latency: `en` and `mask` sampled at edge N → `blank`=0, `sel` valid and `frame`=1 after edge N.
- Each position occupies exactly DWELL cycles with `blank`=0, followed by BLANK_CYC cycles with `blank`=1.
- Frame period = k·(DWELL+BLANK_CYC) cycles, where k is the number of set mask bits (mask held constant).
- `sel` changes only on the same edge where `blank` falls 1→0 (or on a SHOW→SHOW edge when `BLANK_CYC`=0). It never changes while the consumer is mid-blank-exit.
- Stop latency: `en`=0 sampled at edge M → `blank`=1 after edge M.
- Reset assertion forces the reset values immediately, independent of `clk`. After deassertion the block resumes from IDLE.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with `en`=0 → `sel`=0, `blank`=1, `frame`=0 for 20 cycles.
- Full scan: DWELL=4, BLANK_CYC=1, mask=4'b1111, `en`=1 → `sel` runs 0,1,2,3 with each value unblanked for 4 cycles and 1 blank cycle between. `frame` pulses every 20 cycles, always with `sel`=0.
- Sparse mask: mask=4'b1010 → `sel` alternates 1,3,1,3. `frame` pulses only when `sel`=1, with period 10. `sel` never takes 0 or 2 while `blank`=0.
- Single position: mask=4'b0100 → `sel` stays at 2. `blank` is high 1 cycle in every 5. `frame` pulses at every SHOW entry (period 5).
- Mid-dwell changes:
  - Drop `en` in the 2nd SHOW cycle of `sel`=2 → `blank`=1 after the next edge. Re-raise `en` → restart at `sel`=0 with `frame`=1.
  - Set mask=0 mid-dwell → dwell completes, then IDLE with `blank`=1.
- Async reset mid-SHOW: assert `rst_n`=0 between clock edges → `blank`=1, `sel`=0 and `frame`=0 immediately. After release with `en`=1 and mask=4'b1111, scanning restarts at `sel`=0.
